rhythm_recorder: RTL and testbench
==================================

Name: rhythm_recorder

Overview:
- Writer side of the rhythm-map interface: captures player button presses, quantised to the 8 Hz beat tick, into a MAP_LEN-bit rhythm map.
- The completed map uses the same bit ordering the playback datapath consumes, so it can be loaded into the playback shifter directly.
- Bit 0 holds the first beat. Playback shifts right, so bit 0 reaches the hit window first.
- Sits between the GPIO push-key input, the 8 Hz tick generator and the playback datapath's map load input.

Parameters:
- MAP_LEN, 191: number of beat slots in the map.
- SYNC_STAGES, 2: synchroniser flops on the raw button input (minimum 2).
- DEBOUNCE_CYCLES, 250000: clk cycles the input must be stable before it is accepted. Used only with RECORDER_DEBOUNCE_EN.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide pulse per beat slot (8 Hz).
- start  in  1  one-clk pulse; clears the map and begins recording.
- stop  in  1  one-clk pulse; ends recording early.
- button_n  in  1  raw push key, active-low (0 = pressed), asynchronous.
- rhythm_map  out  MAP_LEN  recorded map. Bit i = note at beat i.
- map_valid  out  1  high while rhythm_map holds a complete recording.
- recording  out  1  high in the REC state.
- slot_cnt  out  8  beat slots filled so far, 0..MAP_LEN.
- note_count  out  8  presses recorded; saturates at 255.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rhythm_map=0, map_valid=0, recording=0, slot_cnt=0, note_count=0, pending=0. Synchroniser and debounce state are preset to "released" (1).
- Button path:
  - button_n passes through SYNC_STAGES flops.
  - A press event is a 1->0 transition of the conditioned signal, one clk wide.
  - Holding the button produces only one event.
- pending flag:
  - Set by a press event while in REC.
  - Cleared when consumed by a tick.
  - If a press event and a tick occur in the same clk, the press belongs to the slot being closed by that tick: the shifted-in bit is 1 and pending ends at 0.
- States:
  - IDLE: outputs hold. start -> REC.
  - REC:
    - On each tick: rhythm_map <= {pending|press, rhythm_map[MAP_LEN-1:1]}, slot_cnt+1, note_count+1 (saturating) if the shifted-in bit is 1.
    - The tick that makes slot_cnt==MAP_LEN -> DONE.
    - stop (without start) -> PAD.
  - PAD:
    - Shifts in one 0 per clk (no tick needed), slot_cnt+1 each clk.
    - When slot_cnt reaches MAP_LEN -> DONE.
    - Ticks, presses and stop are ignored.
  - DONE: map_valid=1, outputs hold. start -> REC.
- Entering REC from any state, via start:
  - Next clk: rhythm_map=0, slot_cnt=0, note_count=0, pending=0, map_valid=0, recording=1.
  - A tick in the same clk as start is ignored.
- Priority: start beats stop beats tick when they coincide. start in REC or PAD restarts the recording.
- Placement: after a full MAP_LEN-tick recording, the first recorded slot sits at bit 0. After PAD, the recorded slots occupy the low bits in order and the padded zeros occupy the high bits.
- Latency:
  - Press to pending: SYNC_STAGES+1 clk.
  - map_valid rises 1 clk after the last shift.
- rst during REC or PAD aborts immediately to the reset values. No partial map survives.

Optional Feature:
- RECORDER_DEBOUNCE_EN defined:
  - A counter follows the synchroniser.
  - The conditioned signal changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive clk.
  - Any bounce restarts the count.
  - Press latency becomes SYNC_STAGES+DEBOUNCE_CYCLES+1 clk.
- Undefined: conditioned signal = synchroniser output; no counter is synthesised.

Decomposition:
- Shared package rhythm_pkg:
  - state encoding localparams REC_IDLE=2'd0, REC_REC=2'd1, REC_PAD=2'd2, REC_DONE=2'd3;
  - RHYTHM_MAP_LEN=191;
  - BEAT_HZ=8;
  - accuracy codes shared with playback.
- One sub-module: button_conditioner (synchroniser, optional debounce, falling-edge pulse output).

Test Plan (MAP_LEN=8, DEBOUNCE_CYCLES=4):
- rst=1 for 2 clk while button_n toggles -> all outputs 0, state IDLE, no press counted.
- start; 8 ticks; press before ticks 1, 3 and 8 -> rhythm_map=8'b1000_0101, note_count=3, slot_cnt=8, map_valid=1 one clk after the 8th tick.
- Press edge in the same clk as tick 2 -> bit 1 set and bit 2 clear; holding the button 5 ticks -> only one bit set.
- start; presses at ticks 1 and 2; stop after tick 3 -> PAD lasts 5 clk, rhythm_map=8'b0000_0011, map_valid=1; ticks during PAD do not change the map.
- start and stop in the same clk while in REC -> restart: map=0, slot_cnt=0, recording=1. rst at slot 5 -> all reset values next clk.
- With RECORDER_DEBOUNCE_EN: 3-clk glitch low -> no note; 6-clk low -> one note. Without the macro: the 3-clk glitch records one note.

Source files
------------

// File: rtl/rhythm_pkg.sv
// rtl/rhythm_pkg.sv - shared rhythm-map constants, recorder state codes and accuracy codes
package rhythm_pkg;

  localparam logic [1:0] REC_IDLE = 2'd0;
  localparam logic [1:0] REC_REC  = 2'd1;
  localparam logic [1:0] REC_PAD  = 2'd2;
  localparam logic [1:0] REC_DONE = 2'd3;

  localparam int RHYTHM_MAP_LEN = 191;
  localparam int BEAT_HZ        = 8;

  // Hit grading, shared with the playback datapath
  typedef enum logic [1:0] {
    ACC_MISS    = 2'd0,
    ACC_GOOD    = 2'd1,
    ACC_GREAT   = 2'd2,
    ACC_PERFECT = 2'd3
  } accuracy_t;

endpackage

// File: rtl/rhythm_recorder_if.sv
// rtl/rhythm_recorder_if.sv - recorder control/status bundle; master drives controls, slave is the recorder
interface rhythm_recorder_if
  import rhythm_pkg::*;
#(
  parameter int MAP_LEN = RHYTHM_MAP_LEN
);

  logic               tick;
  logic               start;
  logic               stop;
  logic               button_n;
  logic [MAP_LEN-1:0] rhythm_map;
  logic               map_valid;
  logic               recording;
  logic [7:0]         slot_cnt;
  logic [7:0]         note_count;

  modport master (
    output tick, start, stop, button_n,
    input  rhythm_map, map_valid, recording, slot_cnt, note_count
  );

  modport slave (
    input  tick, start, stop, button_n,
    output rhythm_map, map_valid, recording, slot_cnt, note_count
  );

endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchroniser, optional debounce (RECORDER_DEBOUNCE_EN), one-clk press pulse
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_n,
  output logic press
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("button_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   sync_out;
  logic                   cond;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], button_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

`ifdef RECORDER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;

  // Counter runs only while the input disagrees with the accepted level; any bounce zeroes it
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync_out != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      db_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign cond = db_q;
`else
  assign cond = sync_out;
`endif

  always_comb begin
    prev_d = cond;
    press  = prev_q & ~cond;
  end

endmodule

// File: rtl/rhythm_recorder.sv
// rtl/rhythm_recorder.sv - quantises button presses to beat ticks into a rhythm map
// RECORDER_DEBOUNCE_EN enables the debounce counter in button_conditioner.
module rhythm_recorder
  import rhythm_pkg::*;
#(
  parameter int MAP_LEN         = RHYTHM_MAP_LEN,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic            clk,
  input  logic            rst,
  rhythm_recorder_if.slave bus
);

  if (MAP_LEN < 2 || MAP_LEN > 255) begin : g_bad_len
    $error("rhythm_recorder: MAP_LEN must be in 2..255");
  end

  localparam logic [7:0] LAST_SLOT = 8'(MAP_LEN - 1);

  logic [1:0]         state_q, state_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [7:0]         slot_q, slot_d;
  logic [7:0]         notes_q, notes_d;
  logic               pending_q, pending_d;
  logic               press;
  logic               shift_bit;

  button_conditioner #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button (
    .clk      (clk),
    .rst      (rst),
    .button_n (bus.button_n),
    .press    (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= REC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = REC_REC;
    end else begin
      case (state_q)
        REC_REC: begin
          if (bus.stop) begin
            state_d = REC_PAD;
          end else if (bus.tick && slot_q == LAST_SLOT) begin
            state_d = REC_DONE;
          end
        end
        REC_PAD: begin
          if (slot_q == LAST_SLOT) begin
            state_d = REC_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.recording  = (state_q == REC_REC);
    bus.map_valid  = (state_q == REC_DONE);
    bus.rhythm_map = map_q;
    bus.slot_cnt   = slot_q;
    bus.note_count = notes_q;
  end

  // A press arriving with the tick belongs to the slot that tick closes
  assign shift_bit = pending_q | press;

  always_comb begin
    map_d     = map_q;
    slot_d    = slot_q;
    notes_d   = notes_q;
    pending_d = pending_q;
    if (bus.start) begin
      map_d     = '0;
      slot_d    = '0;
      notes_d   = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        REC_REC: begin
          if (!bus.stop) begin
            if (bus.tick) begin
              map_d     = {shift_bit, map_q[MAP_LEN-1:1]};
              slot_d    = slot_q + 8'd1;
              pending_d = 1'b0;
              if (shift_bit && notes_q != 8'hFF) begin
                notes_d = notes_q + 8'd1;
              end
            end else if (press) begin
              pending_d = 1'b1;
            end
          end
        end
        REC_PAD: begin
          map_d  = {1'b0, map_q[MAP_LEN-1:1]};
          slot_d = slot_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q     <= '0;
      slot_q    <= '0;
      notes_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      map_q     <= map_d;
      slot_q    <= slot_d;
      notes_q   <= notes_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_rhythm_recorder.sv
// tb/tb_rhythm_recorder.sv - directed self-checking bench for rhythm_recorder (MAP_LEN=8)
module tb_rhythm_recorder;

  localparam int MAP_LEN = 8;
`ifdef RECORDER_DEBOUNCE_EN
  localparam int PRESS_LAT = 7;
  localparam int NOTE_G    = 0;
`else
  localparam int PRESS_LAT = 3;
  localparam int NOTE_G    = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  rhythm_recorder_if #(.MAP_LEN(MAP_LEN)) bus ();

  rhythm_recorder #(
    .MAP_LEN         (MAP_LEN),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic press();
    bus.button_n = 1'b0;
    repeat (PRESS_LAT) step();
    bus.button_n = 1'b1;
    repeat (PRESS_LAT) step();
  endtask

  initial begin
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.button_n = 1'b1;

    // Reset while the button chatters
    repeat (2) begin
      bus.button_n = 1'b0;
      #2 bus.button_n = 1'b1;
      #2 bus.button_n = 1'b0;
      step();
    end
    check_eq("rst_map", 32'(bus.rhythm_map), 32'h0);
    check_eq("rst_valid", 32'(bus.map_valid), 32'h0);
    check_eq("rst_rec", 32'(bus.recording), 32'h0);
    check_eq("rst_slot", 32'(bus.slot_cnt), 32'h0);
    check_eq("rst_notes", 32'(bus.note_count), 32'h0);
    rst = 1'b0;
    bus.button_n = 1'b1;
    repeat (PRESS_LAT + 2) step();
    check_eq("idle_notes", 32'(bus.note_count), 32'h0);
    check_eq("idle_rec", 32'(bus.recording), 32'h0);

    // Full recording, presses before ticks 1, 3 and 8
    pulse_start();
    check_eq("rec_on", 32'(bus.recording), 32'h1);
    check_eq("rec_slot0", 32'(bus.slot_cnt), 32'h0);
    for (int t = 1; t <= 8; t++) begin
      if (t == 1 || t == 3 || t == 8) press();
      do_tick();
      if (t == 7) begin
        check_eq("full_map7", 32'(bus.rhythm_map), 32'h0A);
        check_eq("full_valid7", 32'(bus.map_valid), 32'h0);
      end
    end
    check_eq("full_map", 32'(bus.rhythm_map), 32'h85);
    check_eq("full_notes", 32'(bus.note_count), 32'h3);
    check_eq("full_slot", 32'(bus.slot_cnt), 32'h8);
    check_eq("full_valid", 32'(bus.map_valid), 32'h1);
    check_eq("full_rec_off", 32'(bus.recording), 32'h0);

    // Press edge coincident with tick 2, then held across five ticks
    pulse_start();
    do_tick();
    bus.button_n = 1'b0;
    repeat (PRESS_LAT - 1) step();
    do_tick();
    repeat (5) do_tick();
    bus.button_n = 1'b1;
    repeat (PRESS_LAT) step();
    do_tick();
    check_eq("coinc_map", 32'(bus.rhythm_map), 32'h02);
    check_eq("coinc_notes", 32'(bus.note_count), 32'h1);
    check_eq("coinc_valid", 32'(bus.map_valid), 32'h1);

    // Early stop then padding; ticks during PAD are ignored
    pulse_start();
    press();
    do_tick();
    press();
    do_tick();
    do_tick();
    check_eq("pad_pre_map", 32'(bus.rhythm_map), 32'h60);
    bus.stop = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.stop = 1'b0;
    check_eq("pad_rec_off", 32'(bus.recording), 32'h0);
    check_eq("pad_slot3", 32'(bus.slot_cnt), 32'h3);
    repeat (4) step();
    check_eq("pad_slot7", 32'(bus.slot_cnt), 32'h7);
    check_eq("pad_valid4", 32'(bus.map_valid), 32'h0);
    step();
    bus.tick = 1'b0;
    check_eq("pad_valid5", 32'(bus.map_valid), 32'h1);
    check_eq("pad_map", 32'(bus.rhythm_map), 32'h03);
    check_eq("pad_notes", 32'(bus.note_count), 32'h2);
    do_tick();
    check_eq("done_hold", 32'(bus.rhythm_map), 32'h03);

    // Restart via start+stop(+tick), then reset mid-recording
    pulse_start();
    press();
    do_tick();
    do_tick();
    check_eq("mid_map", 32'(bus.rhythm_map), 32'h40);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.tick = 1'b0;
    check_eq("rs_map", 32'(bus.rhythm_map), 32'h0);
    check_eq("rs_slot", 32'(bus.slot_cnt), 32'h0);
    check_eq("rs_rec", 32'(bus.recording), 32'h1);
    check_eq("rs_notes", 32'(bus.note_count), 32'h0);
    press();
    repeat (5) do_tick();
    check_eq("slot5", 32'(bus.slot_cnt), 32'h5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("ab_map", 32'(bus.rhythm_map), 32'h0);
    check_eq("ab_slot", 32'(bus.slot_cnt), 32'h0);
    check_eq("ab_rec", 32'(bus.recording), 32'h0);
    check_eq("ab_notes", 32'(bus.note_count), 32'h0);
    check_eq("ab_valid", 32'(bus.map_valid), 32'h0);

    // Glitch (3 clk low) versus a real press (6 clk low)
    pulse_start();
    bus.button_n = 1'b0;
    repeat (3) step();
    bus.button_n = 1'b1;
    repeat (PRESS_LAT + 2) step();
    do_tick();
    check_eq("glitch_notes", 32'(bus.note_count), 32'(NOTE_G));
    check_eq("glitch_bit", 32'(bus.rhythm_map[7]), 32'(NOTE_G));
    bus.button_n = 1'b0;
    repeat (6) step();
    bus.button_n = 1'b1;
    repeat (PRESS_LAT + 2) step();
    do_tick();
    check_eq("long_notes", 32'(bus.note_count), 32'(NOTE_G + 1));
    check_eq("long_bit", 32'(bus.rhythm_map[7]), 32'h1);
    check_eq("long_slot", 32'(bus.slot_cnt), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
